// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace monitor: FSM states, stop causes and the trace entry payload.
package commit_trace_pkg;

  localparam int unsigned TRACE_XLEN = 32;
  localparam int unsigned REG_AW     = 5;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STOPPED = 2'd1,
    ST_DUMP    = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_HALT    = 2'd1,
    CAUSE_TIMEOUT = 2'd2,
    CAUSE_FORCED  = 2'd3
  } stop_cause_e;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [REG_AW-1:0]     rd_addr;
    logic [TRACE_XLEN-1:0] rd_data;
    logic                  wren;
  } trace_entry_t;

endpackage

// File: rtl/commit_trace_monitor_ring_buf.sv
// Circular trace storage: overwrite-oldest write port, saturating count, registered read port.
module trace_ring_buf
  import commit_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_wr_en,
  input  trace_entry_t             i_wr_entry,
  input  logic                     i_rd_start,
  input  logic                     i_rd_next,
  output trace_entry_t             o_rd_entry,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  trace_entry_t          mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         base;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         rd_ptr_nxt;
  logic [CW-1:0]         count;
  trace_entry_t          rd_q;

  // Read pointer restarts at the oldest entry and steps one per accepted transfer.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    if (i_clear)         rd_ptr_nxt = '0;
    else if (i_rd_start) rd_ptr_nxt = base;
    else if (i_rd_next)  rd_ptr_nxt = rd_ptr + AW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en && !i_clear) mem[wr_ptr] <= i_wr_entry;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      base   <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rd_q   <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      rd_q   <= mem[rd_ptr_nxt];
      if (i_clear) begin
        wr_ptr <= '0;
        base   <= '0;
        count  <= '0;
        rd_q   <= '0;
      end else if (i_wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        // Full ring: the oldest slot is the one being overwritten.
        if (count != CW'(DEPTH)) count <= count + CW'(1);
        else                     base  <= base + AW'(1);
      end
    end
  end

  assign o_rd_entry = rd_q;
  assign o_count    = count;

endmodule

// File: rtl/commit_trace_monitor.sv
// Commit-stream trace monitor: capture in RUN, stop on halt/timeout/force, then stream oldest-first.
// Build option TRACE_FILTER_EN: record only commits that write a non-zero destination register.
module commit_trace_monitor
  import commit_trace_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HALT_CYCLES = 8,
  parameter int unsigned MAX_CYCLES  = 1000,
  parameter int unsigned XLEN        = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [XLEN-1:0]        i_pc,
  input  logic                   i_insn_vld,
  input  logic                   i_rd_wren,
  input  logic [4:0]             i_rd_addr,
  input  logic [XLEN-1:0]        i_rd_data,
  input  logic                   i_dump_start,
  input  logic                   i_clear,
  input  logic                   i_rd_rdy,
  output logic                   o_rd_vld,
  output logic [XLEN-1:0]        o_trace_pc,
  output logic [4:0]             o_trace_rd_addr,
  output logic [XLEN-1:0]        o_trace_rd_data,
  output logic                   o_trace_wren,
  output logic                   o_stopped,
  output logic [1:0]             o_stop_cause,
  output logic [31:0]            o_cycle_cnt,
  output logic [$clog2(DEPTH):0] o_entry_cnt,
  output logic                   o_dump_done
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = $clog2(HALT_CYCLES + 1);

  state_e        state, state_nxt;
  stop_cause_e   cause, cause_nxt;
  logic [31:0]   cycle_cnt, cycle_nxt;
  logic [XLEN-1:0] last_pc, last_pc_nxt;
  logic [SW-1:0] stall_cnt, stall_nxt;
  logic [CW-1:0] dump_left, dump_left_nxt, entry_cnt;
  logic          primed, primed_nxt;
  logic          rd_vld_q, rd_vld_nxt;
  logic          dump_done_q, dump_done_nxt;
  logic          stopped_q, stopped_nxt;
  logic          capture_c, wr_en_c, rd_start_c, rd_next_c;
  trace_entry_t  wr_entry, rd_entry;

`ifdef TRACE_FILTER_EN
  assign capture_c = i_insn_vld && i_rd_wren && (i_rd_addr != 5'd0);
`else
  assign capture_c = i_insn_vld;
`endif

  assign wr_entry = '{pc: TRACE_XLEN'(i_pc), rd_addr: i_rd_addr,
                      rd_data: TRACE_XLEN'(i_rd_data), wren: i_rd_wren};

  trace_ring_buf #(.DEPTH(DEPTH)) u_ring (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (i_clear),
    .i_wr_en    (wr_en_c),
    .i_wr_entry (wr_entry),
    .i_rd_start (rd_start_c),
    .i_rd_next  (rd_next_c),
    .o_rd_entry (rd_entry),
    .o_count    (entry_cnt)
  );

  // Next-state, halt/timeout detection and dump sequencing.
  always_comb begin
    state_nxt     = state;
    cause_nxt     = cause;
    cycle_nxt     = cycle_cnt;
    last_pc_nxt   = last_pc;
    stall_nxt     = stall_cnt;
    dump_left_nxt = dump_left;
    primed_nxt    = primed;
    wr_en_c       = 1'b0;
    rd_start_c    = 1'b0;
    rd_next_c     = 1'b0;
    rd_vld_nxt    = 1'b0;
    dump_done_nxt = 1'b0;
    stopped_nxt   = 1'b0;
    if (i_clear) begin
      state_nxt     = ST_RUN;
      cause_nxt     = CAUSE_NONE;
      cycle_nxt     = '0;
      last_pc_nxt   = '0;
      stall_nxt     = '0;
      dump_left_nxt = '0;
      primed_nxt    = 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          cycle_nxt = cycle_cnt + 32'd1;
          wr_en_c   = capture_c;
          if (i_insn_vld) begin
            last_pc_nxt = i_pc;
            stall_nxt   = (i_pc == last_pc) ? stall_cnt + SW'(1) : SW'(1);
          end
          if (i_dump_start) begin
            state_nxt  = ST_DUMP;
            cause_nxt  = CAUSE_FORCED;
            primed_nxt = 1'b0;
          end else if (i_insn_vld && (stall_nxt == SW'(HALT_CYCLES))) begin
            state_nxt = ST_STOPPED;
            cause_nxt = CAUSE_HALT;
          end else if (cycle_nxt == 32'(MAX_CYCLES)) begin
            state_nxt = ST_STOPPED;
            cause_nxt = CAUSE_TIMEOUT;
          end
        end
        ST_STOPPED: begin
          if (i_dump_start) begin
            state_nxt  = ST_DUMP;
            primed_nxt = 1'b0;
          end
        end
        ST_DUMP: begin
          // First DUMP cycle loads the oldest entry; buffer contents are settled by then.
          if (!primed) begin
            primed_nxt    = 1'b1;
            rd_start_c    = 1'b1;
            dump_left_nxt = entry_cnt;
            if (entry_cnt == '0) state_nxt = ST_DONE;
          end else if (rd_vld_q && i_rd_rdy) begin
            rd_next_c     = 1'b1;
            dump_left_nxt = dump_left - CW'(1);
            if (dump_left == CW'(1)) state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
        end
        default: state_nxt = ST_RUN;
      endcase
    end
    rd_vld_nxt    = (state_nxt == ST_DUMP) && primed_nxt && (dump_left_nxt != '0);
    dump_done_nxt = (state_nxt == ST_DONE);
    stopped_nxt   = (state_nxt != ST_RUN);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_RUN;
      cause       <= CAUSE_NONE;
      cycle_cnt   <= '0;
      last_pc     <= '0;
      stall_cnt   <= '0;
      dump_left   <= '0;
      primed      <= 1'b0;
      rd_vld_q    <= 1'b0;
      dump_done_q <= 1'b0;
      stopped_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cause       <= cause_nxt;
      cycle_cnt   <= cycle_nxt;
      last_pc     <= last_pc_nxt;
      stall_cnt   <= stall_nxt;
      dump_left   <= dump_left_nxt;
      primed      <= primed_nxt;
      rd_vld_q    <= rd_vld_nxt;
      dump_done_q <= dump_done_nxt;
      stopped_q   <= stopped_nxt;
    end
  end

  assign o_rd_vld        = rd_vld_q;
  assign o_dump_done     = dump_done_q;
  assign o_stopped       = stopped_q;
  assign o_stop_cause    = cause;
  assign o_cycle_cnt     = cycle_cnt;
  assign o_entry_cnt     = entry_cnt;
  assign o_trace_pc      = XLEN'(rd_entry.pc);
  assign o_trace_rd_addr = rd_entry.rd_addr;
  assign o_trace_rd_data = XLEN'(rd_entry.rd_data);
  assign o_trace_wren    = rd_entry.wren;

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Self-checking bench for commit_trace_monitor: directed scenario table, corner sequences, random runs vs a queue model.
module tb_commit_trace_monitor;

  localparam int DEPTH = 16;
  localparam int HALT  = 8;
  localparam int MAXC  = 50;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wren;
  } ent_t;

  typedef struct {
    int idle;
    int distinct;
    int repeats;
    bit force_dump;
    int exp_cause;
    int exp_entries;
    int exp_cycle;
    int rdy_mode;
  } scen_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_pc = '0;
  logic        i_insn_vld = 1'b0;
  logic        i_rd_wren = 1'b0;
  logic [4:0]  i_rd_addr = '0;
  logic [31:0] i_rd_data = '0;
  logic        i_dump_start = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_rd_rdy = 1'b0;
  logic        o_rd_vld;
  logic [31:0] o_trace_pc;
  logic [4:0]  o_trace_rd_addr;
  logic [31:0] o_trace_rd_data;
  logic        o_trace_wren;
  logic        o_stopped;
  logic [1:0]  o_stop_cause;
  logic [31:0] o_cycle_cnt;
  logic [4:0]  o_entry_cnt;
  logic        o_dump_done;

  always #5 i_clk = ~i_clk;

  commit_trace_monitor #(.DEPTH(DEPTH), .HALT_CYCLES(HALT), .MAX_CYCLES(MAXC), .XLEN(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc(i_pc), .i_insn_vld(i_insn_vld),
    .i_rd_wren(i_rd_wren), .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data),
    .i_dump_start(i_dump_start), .i_clear(i_clear), .i_rd_rdy(i_rd_rdy),
    .o_rd_vld(o_rd_vld), .o_trace_pc(o_trace_pc), .o_trace_rd_addr(o_trace_rd_addr),
    .o_trace_rd_data(o_trace_rd_data), .o_trace_wren(o_trace_wren), .o_stopped(o_stopped),
    .o_stop_cause(o_stop_cause), .o_cycle_cnt(o_cycle_cnt), .o_entry_cnt(o_entry_cnt),
    .o_dump_done(o_dump_done)
  );

  int errs = 0;
  int checks = 0;

  // Reference model: a running flag, a cause, a cycle count and a bounded queue of recorded commits.
  bit          m_run;
  int          m_cause;
  int          m_cyc;
  logic [31:0] m_last;
  int          m_stall;
  ent_t        mq[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b1; m_cause = 0; m_cyc = 0; m_last = '0; m_stall = 0;
    mq.delete();
  endtask

  task automatic check_status(input string tag);
    check({tag, " stopped"}, 128'(o_stopped), 128'(!m_run));
    check({tag, " cause"},   128'(o_stop_cause), 128'(m_cause));
    check({tag, " cycles"},  128'(o_cycle_cnt), 128'(m_cyc));
    check({tag, " entries"}, 128'(o_entry_cnt), 128'(mq.size()));
  endtask

  // One clock with the given commit; called and returns at a falling edge.
  task automatic cycle(input bit vld, input logic [31:0] pc, input bit wren, input logic [4:0] rd,
                       input logic [31:0] data, input bit force_dump);
    bit   keep;
    ent_t e;
    i_insn_vld = vld; i_pc = pc; i_rd_wren = wren; i_rd_addr = rd; i_rd_data = data;
    i_dump_start = force_dump;
    if (m_run) begin
      keep = vld;
`ifdef TRACE_FILTER_EN
      keep = vld && wren && (rd != 5'd0);
`endif
      m_cyc++;
      if (keep) begin
        e.pc = pc; e.rd = rd; e.data = data; e.wren = wren;
        mq.push_back(e);
        if (mq.size() > DEPTH) mq.delete(0);
      end
      if (vld) begin
        m_stall = (pc == m_last) ? m_stall + 1 : 1;
        m_last = pc;
      end
      if (force_dump)                     begin m_run = 1'b0; m_cause = 3; end
      else if (vld && m_stall == HALT)    begin m_run = 1'b0; m_cause = 1; end
      else if (m_cyc == MAXC)             begin m_run = 1'b0; m_cause = 2; end
    end
    @(negedge i_clk);
    i_insn_vld = 1'b0; i_dump_start = 1'b0;
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
    model_reset();
  endtask

  // Drain the trace; mode 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready.
  task automatic dump(input bit start, input int mode, input string tag);
    int   idx;
    bit   held_v;
    bit   rdy;
    ent_t held, cur;
    if (start) cycle(1'b0, '0, 1'b0, '0, '0, 1'b1);
    idx = 0; held_v = 1'b0; held = '0;
    for (int c = 0; c < 300 && !o_dump_done; c++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 4 == 0) || (c % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      i_rd_rdy = rdy;
      cur = {o_trace_pc, o_trace_rd_addr, o_trace_rd_data, o_trace_wren};
      if (held_v) begin
        check({tag, " hold vld"}, 128'(o_rd_vld), 128'(1));
        check({tag, " hold data"}, 128'(cur), 128'(held));
      end
      if (o_rd_vld) begin
        if (rdy) begin
          if (idx < mq.size()) check({tag, " entry"}, 128'(cur), 128'(mq[idx]));
          else                 check({tag, " surplus entry"}, 128'(idx), 128'(mq.size()));
          idx++;
          held_v = 1'b0;
        end else begin
          held = cur; held_v = 1'b1;
        end
      end else begin
        held_v = 1'b0;
      end
      @(negedge i_clk);
    end
    i_rd_rdy = 1'b0;
    check({tag, " dump_done"}, 128'(o_dump_done), 128'(1));
    check({tag, " delivered"}, 128'(idx), 128'(mq.size()));
    check({tag, " vld after done"}, 128'(o_rd_vld), 128'(0));
    check({tag, " stopped in done"}, 128'(o_stopped), 128'(1));
  endtask

  scen_t tbl[6];

  initial begin
    logic [31:0] rpc;
    int          n;

    tbl[0] = '{idle: 0,  distinct: 5,  repeats: 8, force_dump: 0, exp_cause: 1, exp_entries: 13, exp_cycle: 13, rdy_mode: 0};
    tbl[1] = '{idle: 0,  distinct: 20, repeats: 0, force_dump: 1, exp_cause: 3, exp_entries: 16, exp_cycle: 21, rdy_mode: 2};
    tbl[2] = '{idle: 60, distinct: 0,  repeats: 0, force_dump: 0, exp_cause: 2, exp_entries: 0,  exp_cycle: 50, rdy_mode: 0};
    tbl[3] = '{idle: 42, distinct: 0,  repeats: 8, force_dump: 0, exp_cause: 1, exp_entries: 8,  exp_cycle: 50, rdy_mode: 1};
    tbl[4] = '{idle: 0,  distinct: 3,  repeats: 0, force_dump: 1, exp_cause: 3, exp_entries: 3,  exp_cycle: 4,  rdy_mode: 1};
    tbl[5] = '{idle: 0,  distinct: 0,  repeats: 0, force_dump: 1, exp_cause: 3, exp_entries: 0,  exp_cycle: 1,  rdy_mode: 0};

    repeat (2) @(negedge i_clk);
    check("reset rd_vld", 128'(o_rd_vld), 128'(0));
    check("reset stopped", 128'(o_stopped), 128'(0));
    check("reset cycles", 128'(o_cycle_cnt), 128'(0));
    check("reset entries", 128'(o_entry_cnt), 128'(0));
    check("reset done", 128'(o_dump_done), 128'(0));
    i_rst_n = 1'b1;
    model_reset();

    // Directed scenarios; every commit writes a non-zero register so the filter build agrees.
    for (int s = 0; s < 6; s++) begin
      do_clear();
      for (int k = 0; k < tbl[s].idle; k++) cycle(1'b0, '0, 1'b0, '0, '0, 1'b0);
      for (int k = 0; k < tbl[s].distinct; k++)
        cycle(1'b1, 32'(4 * k), 1'b1, 5'((k % 31) + 1), 32'(4 * k) ^ 32'hA5A5_0000, 1'b0);
      for (int k = 0; k < tbl[s].repeats; k++)
        cycle(1'b1, 32'(4 * tbl[s].distinct), 1'b1, 5'd7, 32'h1234_0000 + 32'(k), 1'b0);
      if (tbl[s].force_dump) cycle(1'b0, '0, 1'b0, '0, '0, 1'b1);
      check($sformatf("scen%0d cause", s), 128'(o_stop_cause), 128'(tbl[s].exp_cause));
      check($sformatf("scen%0d entries", s), 128'(o_entry_cnt), 128'(tbl[s].exp_entries));
      check($sformatf("scen%0d cycles", s), 128'(o_cycle_cnt), 128'(tbl[s].exp_cycle));
      check($sformatf("scen%0d stopped", s), 128'(o_stopped), 128'(1));
      check_status($sformatf("scen%0d model", s));
      dump(!tbl[s].force_dump, tbl[s].rdy_mode, $sformatf("scen%0d", s));
    end

    // Clear out of DONE empties the buffer and resumes capture.
    do_clear();
    check("clear done flag", 128'(o_dump_done), 128'(0));
    check("clear entries", 128'(o_entry_cnt), 128'(0));
    check("clear cause", 128'(o_stop_cause), 128'(0));
    cycle(1'b1, 32'h300, 1'b1, 5'd3, 32'h0000_0333, 1'b0);
    check("capture after clear", 128'(o_entry_cnt), 128'(1));
    check_status("after clear");

    // Asynchronous reset in the middle of a dump.
    for (int k = 0; k < 10; k++) cycle(1'b1, 32'h400 + 32'(4 * k), 1'b1, 5'd9, 32'(k), 1'b0);
    cycle(1'b0, '0, 1'b0, '0, '0, 1'b1);
    i_rd_rdy = 1'b1;
    repeat (3) @(negedge i_clk);
    check("mid dump vld", 128'(o_rd_vld), 128'(1));
    #2 i_rst_n = 1'b0;
    #1;
    check("async rst vld", 128'(o_rd_vld), 128'(0));
    check("async rst stopped", 128'(o_stopped), 128'(0));
    check("async rst cause", 128'(o_stop_cause), 128'(0));
    check("async rst entries", 128'(o_entry_cnt), 128'(0));
    check("async rst cycles", 128'(o_cycle_cnt), 128'(0));
    check("async rst pc", 128'(o_trace_pc), 128'(0));
    @(negedge i_clk);
    i_rd_rdy = 1'b0;
    i_rst_n = 1'b1;
    model_reset();
    repeat (3) cycle(1'b0, '0, 1'b0, '0, '0, 1'b0);
    check_status("after reset");

    // Three commits, only one changes a register.
    do_clear();
    cycle(1'b1, 32'h200, 1'b0, 5'd5, 32'h1111_1111, 1'b0);
    cycle(1'b1, 32'h204, 1'b1, 5'd0, 32'h2222_2222, 1'b0);
    cycle(1'b1, 32'h208, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
`ifdef TRACE_FILTER_EN
    check("filter entries", 128'(o_entry_cnt), 128'(1));
`else
    check("filter entries", 128'(o_entry_cnt), 128'(3));
`endif
    dump(1'b1, 0, "filter");

    // Random runs against the model.
    for (int it = 0; it < 8; it++) begin
      do_clear();
      rpc = 32'h80;
      n = $urandom_range(10, 60);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 7) == 0) rpc = 32'h80 + 32'(4 * $urandom_range(0, 3));
        cycle(1'($urandom_range(0, 3) != 0), rpc, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), $urandom, 1'b0);
        check_status($sformatf("rand%0d c%0d", it, k));
      end
      cycle(1'($urandom_range(0, 1)), rpc, 1'b1, 5'd4, $urandom, 1'b1);
      check_status($sformatf("rand%0d start", it));
      dump(1'b0, 2, $sformatf("rand%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
    $fatal(1);
  end

endmodule

// File: doc/commit_trace_monitor.md
Name: commit_trace_monitor

Overview:
- Synthesizable debug block beside the singlecycle core; watches the commit stream (o_pc_debug, o_insn_vld, regfile write port).
- Records the last DEPTH committed instructions in a circular trace buffer.
- Detects program end by a self-loop halt or a cycle-budget timeout, then streams the trace out oldest-first over a valid/ready port.
- Replaces fixed-time end-of-run checks and hierarchical register probing with a parametrised hardware mechanism usable on FPGA and in simulation.

Parameters:
- DEPTH, 16, trace entries; power of 2, >=2
- HALT_CYCLES, 8, consecutive valid commits at an unchanged PC that declare halt; >=2
- MAX_CYCLES, 1000, RUN-state cycle budget before timeout; must fit 32 bits
- XLEN, 32, PC/data width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_pc  in  XLEN  PC of the instruction committing this cycle
- i_insn_vld  in  1  commit valid
- i_rd_wren  in  1  regfile write enable this cycle
- i_rd_addr  in  5  destination register
- i_rd_data  in  XLEN  writeback data
- i_dump_start  in  1  begin readout; forces a stop if still running
- i_clear  in  1  return to RUN with an empty buffer
- i_rd_rdy  in  1  consumer ready
- o_rd_vld  out  1  trace entry valid
- o_trace_pc  out  XLEN  entry PC
- o_trace_rd_addr  out  5  entry rd
- o_trace_rd_data  out  XLEN  entry wb data
- o_trace_wren  out  1  entry write flag
- o_stopped  out  1  capture stopped
- o_stop_cause  out  2  0 none, 1 halt, 2 timeout, 3 forced
- o_cycle_cnt  out  32  RUN cycles elapsed
- o_entry_cnt  out  $clog2(DEPTH)+1  valid entries held
- o_dump_done  out  1  all entries delivered

Behaviour:
- Reset (async, any state): state=RUN; pointers, counters and stall count=0; all outputs 0.
- States: RUN, STOPPED, DUMP, DONE.
- RUN:
  - o_cycle_cnt increments every cycle.
  - Each i_insn_vld cycle writes {pc,rd_addr,rd_data,wren} at wr_ptr, wr_ptr+1 mod DEPTH.
  - o_entry_cnt saturates at DEPTH; when full, the oldest entry is overwritten (rd_base advances with wr_ptr).
- Halt detect:
  - Valid commit with i_pc == last valid PC: stall_cnt+1.
  - Valid commit with a different PC: stall_cnt=1.
  - Invalid cycles leave stall_cnt unchanged.
  - stall_cnt reaching HALT_CYCLES: go to STOPPED, cause=1.
- Timeout: o_cycle_cnt reaching MAX_CYCLES goes to STOPPED, cause=2.
- Same-cycle priority: forced(3) > halt(1) > timeout(2).
- The commit on the stopping cycle is recorded. o_cycle_cnt freezes once stopped.
- i_dump_start in RUN: cause=3, go directly to DUMP. In STOPPED: go to DUMP. Ignored in DUMP/DONE.
- DUMP:
  - o_rd_vld=1 while entries remain; data is registered (1-cycle latency from read pointer).
  - Transfer on o_rd_vld && i_rd_rdy; next entry presented the following cycle.
  - Outputs hold stable while o_rd_vld && !i_rd_rdy.
  - After the last transfer, or immediately if o_entry_cnt==0: DONE, o_dump_done=1, o_rd_vld=0.
- No capture outside RUN.
- i_clear in any state: next cycle RUN with pointers, counters and cause cleared. i_clear wins over i_dump_start.
- o_stopped=1 in STOPPED, DUMP, DONE.

Optional Feature:
- Macro TRACE_FILTER_EN.
- Defined: record only commits with i_rd_wren && i_rd_addr!=0 (register-changing instructions). Halt detection still sees every valid commit.
- Undefined: record every valid commit.

Decomposition:
- Package commit_trace_pkg:
  - state enum
  - stop_cause enum (CAUSE_NONE/HALT/TIMEOUT/FORCED)
  - trace_entry_t packed struct {pc, rd_addr, rd_data, wren}
- Sub-module trace_ring_buf: DEPTH x trace_entry_t storage with write port, registered read port, wrap pointers and saturating count.
- The FSM, halt detect and timeout counter stay in the top module.

Test Plan:
- 5 valid commits, PCs 0x0,0x4..0x10, then PC 0x14 repeated 8 valid cycles -> cause=1; o_entry_cnt=13; dump returns 13 entries, first 0x0, last 0x14.
- 20 distinct commits with DEPTH=16, then i_dump_start -> cause=3; dump yields PCs of commits 5..20 in order; o_dump_done after 16 transfers.
- No halt, MAX_CYCLES=50 -> stop at o_cycle_cnt=50 with cause=2. If halt and timeout land on the same cycle -> cause=1.
- Dump with i_rd_rdy toggling 1,0,0,1 -> o_rd_vld stays high; entry data stays stable through stall cycles; no entry skipped or duplicated.
- i_rst_n low mid-DUMP -> all outputs 0 asynchronously, state RUN. i_clear in DONE -> o_entry_cnt=0, o_stop_cause=0, capture resumes.
- TRACE_FILTER_EN build: commits with wren=0 or rd=x0 not recorded; a 3-commit run with only one write to x5=0xDEADBEEF -> dump yields 1 entry {rd=5, data=0xDEADBEEF}.
